// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle controller for a small RV32 subset
// (R, I-ALU, LUI, LW, SW, BEQ/BNE, JAL).
// Each instruction walks FETCH -> DECODE -> EXEC -> [MEM] -> [WB]. The
// controller owns PC, the instruction register and the latched PC+4, and
// drives registered strobes for the memory port, register file and ALU.
// Optional build macro MC_CTRL_TRAP_ILLEGAL_EN: when defined, an illegal
// opcode parks the FSM in HALT until reset. When it is undefined, an
// illegal opcode is skipped as a NOP and halt is tied low.
module mc_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  input  logic                  Zero,
  input  logic [DATA_WIDTH-1:0] ImmExt,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  AdrSrc,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic                  RegWrite,
  output logic                  ALUSrc,
  output logic [2:0]            ALUControl,
  output logic [1:0]            ResultSrc,
  output logic                  busy,
  output logic                  halt
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_IALU, C_LUI, C_LW, C_SW, C_BR, C_JAL, C_ILL
  } class_e;

  // Map an opcode onto the instruction class that steers the FSM.
  function automatic class_e classify(input logic [6:0] op);
    case (op)
      OP_R:    return C_R;
      OP_IALU: return C_IALU;
      OP_LUI:  return C_LUI;
      OP_LW:   return C_LW;
      OP_SW:   return C_SW;
      OP_BR:   return C_BR;
      OP_JAL:  return C_JAL;
      default: return C_ILL;
    endcase
  endfunction

  // ALU operation. Only R-type honours funct7[5] (sub). Loads, stores and
  // LUI use add. Branches compare by subtracting.
  function automatic logic [2:0] alu_decode(input class_e cls, input logic [2:0] f3,
                                            input logic f7b5);
    logic [2:0] op;
    op = ALU_ADD;
    case (cls)
      C_R, C_IALU: begin
        case (f3)
          3'b000:  op = (cls == C_R && f7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  op = ALU_SLT;
          3'b110:  op = ALU_OR;
          3'b111:  op = ALU_AND;
          default: op = ALU_ADD;
        endcase
      end
      C_BR:    op = ALU_SUB;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Classes whose ALU B operand is the immediate.
  function automatic logic uses_imm(input class_e cls);
    return (cls == C_IALU) || (cls == C_LUI) || (cls == C_LW) || (cls == C_SW);
  endfunction

  state_e                  state_q,      state_d;
  logic [ADDR_WIDTH-1:0]   pc_q,         pc_d;
  logic [DATA_WIDTH-1:0]   instr_q,      instr_d;
  logic [ADDR_WIDTH-1:0]   pc_plus4_q,   pc_plus4_d;
  logic                    mem_req_q,    mem_req_d;
  logic                    mem_we_q,     mem_we_d;
  logic                    adr_src_q,    adr_src_d;
  logic                    reg_write_q,  reg_write_d;
  logic                    alu_src_q,    alu_src_d;
  logic [2:0]              alu_ctrl_q,   alu_ctrl_d;
  logic [1:0]              result_src_q, result_src_d;

  class_e                cls_q;
  class_e                cls_d;
  logic [ADDR_WIDTH-1:0] imm_a;
  logic [ADDR_WIDTH-1:0] pc_target;
  logic                  br_taken;

  assign cls_q     = classify(instr_q[6:0]);
  assign cls_d     = classify(instr_d[6:0]);
  // The immediate is cut down (or widened) to PC width. PC sums wrap naturally.
  assign imm_a     = ADDR_WIDTH'(ImmExt);
  assign pc_target = pc_q + imm_a;
  // funct3[0] separates BNE (1) from BEQ (0).
  assign br_taken  = instr_q[12] ? ~Zero : Zero;

  // Next-state, PC and instruction-register update.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          instr_d    = mem_rdata;
          pc_plus4_d = pc_q + ADDR_WIDTH'(4);
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls_q == C_ILL) begin
`ifdef MC_CTRL_TRAP_ILLEGAL_EN
          state_d = S_HALT;
`else
          pc_d    = pc_plus4_q;
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_LW, C_SW: state_d = S_MEM;
          C_BR: begin
            pc_d    = br_taken ? pc_target : pc_plus4_q;
            state_d = S_FETCH;
          end
          C_JAL: begin
            pc_d    = pc_target;
            state_d = S_WB;
          end
          C_ILL:   state_d = S_FETCH;
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (cls_q == C_LW) begin
            state_d = S_WB;
          end else begin
            pc_d    = pc_plus4_q;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        if (cls_q != C_JAL) pc_d = pc_plus4_q;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Control strobes for the upcoming state, registered so they come straight from flops.
  always_comb begin
    mem_req_d    = 1'b0;
    mem_we_d     = 1'b0;
    adr_src_d    = 1'b0;
    reg_write_d  = 1'b0;
    alu_src_d    = 1'b0;
    alu_ctrl_d   = ALU_ADD;
    result_src_d = RES_ALU;
    case (state_d)
      S_FETCH: mem_req_d = 1'b1;
      S_EXEC: begin
        alu_src_d  = uses_imm(cls_d);
        alu_ctrl_d = alu_decode(cls_d, instr_d[14:12], instr_d[30]);
      end
      S_MEM: begin
        mem_req_d  = 1'b1;
        adr_src_d  = 1'b1;
        mem_we_d   = (cls_d == C_SW);
        alu_src_d  = uses_imm(cls_d);
        alu_ctrl_d = alu_decode(cls_d, instr_d[14:12], instr_d[30]);
      end
      S_WB: begin
        reg_write_d  = 1'b1;
        alu_src_d    = uses_imm(cls_d);
        alu_ctrl_d   = alu_decode(cls_d, instr_d[14:12], instr_d[30]);
        result_src_d = (cls_d == C_LW)  ? RES_MEM :
                       (cls_d == C_JAL) ? RES_PC4 : RES_ALU;
      end
      default: ;
    endcase
  end

  // All state and registered outputs; reset is asynchronous, so strobes drop mid-access.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      pc_plus4_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      adr_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= ALU_ADD;
      result_src_q <= RES_ALU;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc_plus4_q   <= pc_plus4_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      adr_src_q    <= adr_src_d;
      reg_write_q  <= reg_write_d;
      alu_src_q    <= alu_src_d;
      alu_ctrl_q   <= alu_ctrl_d;
      result_src_q <= result_src_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign AdrSrc     = adr_src_q;
  assign PC         = pc_q;
  assign Instr      = instr_q;
  assign RegWrite   = reg_write_q;
  assign ALUSrc     = alu_src_q;
  assign ALUControl = alu_ctrl_q;
  assign ResultSrc  = result_src_q;
  assign busy       = (state_q != S_IDLE);
`ifdef MC_CTRL_TRAP_ILLEGAL_EN
  assign halt       = (state_q == S_HALT);
`else
  assign halt       = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl. A memory responder follows
// mem_req/AdrSrc and inserts wait states. Directed vectors and random
// instruction streams are scored against a behavioural model. The model
// works from instruction class, cycle budgets and PC arithmetic.
module tb_mc_ctrl;

  logic        CLK = 1'b0;
  logic        rst;
  logic        trigger;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        Zero;
  logic [31:0] ImmExt;
  logic        mem_req;
  logic        mem_we;
  logic        AdrSrc;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic        RegWrite;
  logic        ALUSrc;
  logic [2:0]  ALUControl;
  logic [1:0]  ResultSrc;
  logic        busy;
  logic        halt;

  int total = 0;
  int bad   = 0;

  mc_ctrl dut (
    .CLK        (CLK),
    .rst        (rst),
    .trigger    (trigger),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .Zero       (Zero),
    .ImmExt     (ImmExt),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .AdrSrc     (AdrSrc),
    .PC         (PC),
    .Instr      (Instr),
    .RegWrite   (RegWrite),
    .ALUSrc     (ALUSrc),
    .ALUControl (ALUControl),
    .ResultSrc  (ResultSrc),
    .busy       (busy),
    .halt       (halt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  typedef enum {K_R, K_I, K_LUI, K_LW, K_SW, K_BR, K_JAL, K_BAD} kind_e;

  typedef struct {
    int         cycles;
    int         rw;
    int         rw_at;
    int         we;
    int         memc;
    logic [1:0] rsrc;
    logic [2:0] alu;
    logic       alusrc;
    bit         timeout;
  } obs_t;

  typedef struct {
    int          cycles;
    logic [31:0] pc;
    int          rw;
    int          we;
    int          memc;
    logic [1:0]  rsrc;
    logic [2:0]  alu;
    bit          alu_known;
    logic        alusrc;
    bit          src_known;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic        zero;
    logic [31:0] imm;
    int          fw;
    int          mw;
    logic [31:0] start_pc;
    int          exp_cycles;
    logic [31:0] exp_pc;
    int          exp_rw;
    logic [1:0]  exp_rsrc;
    logic [2:0]  exp_alu;
    logic        exp_alusrc;
    bit          chk_alu;
    bit          chk_src;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, got, want);
    end
  endtask

  function automatic kind_e kind_of(input logic [31:0] ins);
    case (ins[6:0])
      7'h33:   return K_R;
      7'h13:   return K_I;
      7'h37:   return K_LUI;
      7'h03:   return K_LW;
      7'h23:   return K_SW;
      7'h63:   return K_BR;
      7'h6F:   return K_JAL;
      default: return K_BAD;
    endcase
  endfunction

  // Reference model: what one instruction should cost and leave behind.
  function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic zero, input logic [31:0] imm,
                                   input int fw, input int mw);
    exp_t  e;
    kind_e k;
    k = kind_of(ins);
    e.pc = pc + 32'd4;
    e.rw = 0; e.we = 0; e.memc = 0; e.rsrc = 2'b00;
    e.alu = 3'b000; e.alu_known = 1'b1; e.alusrc = 1'b0; e.src_known = 1'b1;
    case (k)
      K_R, K_I: begin
        e.cycles = 4 + fw; e.rw = 1; e.alusrc = (k == K_I);
        case (ins[14:12])
          3'b000:  e.alu = (k == K_R && ins[30]) ? 3'b001 : 3'b000;
          3'b111:  e.alu = 3'b010;
          3'b110:  e.alu = 3'b011;
          3'b010:  e.alu = 3'b101;
          default: e.alu_known = 1'b0;
        endcase
      end
      K_LUI: begin e.cycles = 4 + fw; e.rw = 1; e.src_known = 1'b0; end
      K_LW: begin
        e.cycles = 5 + fw + mw; e.rw = 1; e.memc = mw + 1; e.rsrc = 2'b01; e.alusrc = 1'b1;
      end
      K_SW: begin
        e.cycles = 4 + fw + mw; e.we = mw + 1; e.memc = mw + 1; e.alusrc = 1'b1;
      end
      K_BR: begin
        e.cycles = 3 + fw; e.alu = 3'b001;
        if ((ins[12] == 1'b0) ? zero : !zero) e.pc = pc + imm;
      end
      K_JAL: begin
        e.cycles = 4 + fw; e.rw = 1; e.rsrc = 2'b10; e.pc = pc + imm;
        e.alu_known = 1'b0; e.src_known = 1'b0;
      end
      default: begin e.cycles = 2 + fw; e.alu_known = 1'b0; e.src_known = 1'b0; end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [2:0]  alu_f3 [4];
    int          k;
    alu_f3 = '{3'b000, 3'b111, 3'b110, 3'b010};
    r = $urandom;
`ifdef MC_CTRL_TRAP_ILLEGAL_EN
    k = $urandom_range(0, 6);
`else
    k = $urandom_range(0, 7);
`endif
    case (k)
      0: begin
        r[6:0] = 7'h33; r[14:12] = alu_f3[$urandom_range(0, 3)];
        r[31:25] = (r[14:12] == 3'b000 && r[30]) ? 7'h20 : 7'h00;
      end
      1: begin r[6:0] = 7'h13; r[14:12] = alu_f3[$urandom_range(0, 3)]; end
      2: r[6:0] = 7'h37;
      3: begin r[6:0] = 7'h03; r[14:12] = 3'b010; end
      4: begin r[6:0] = 7'h23; r[14:12] = 3'b010; end
      5: begin r[6:0] = 7'h63; r[14:13] = 2'b00; end
      6: r[6:0] = 7'h6F;
      default: r[6:0] = 7'h7F;
    endcase
    return r;
  endfunction

  // Runs one instruction starting at a negedge with the DUT in FETCH. It
  // returns at the negedge where the next fetch is requested, or when the
  // cycle budget runs out.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, output obs_t o);
    int f, m, cyc;
    bit fetched, done;
    f = fw; m = mw; cyc = 0; fetched = 0; done = 0;
    o = '{default: 0};
    while (!done) begin
      if (fetched && mem_req && !AdrSrc) begin
        done = 1;
      end else if (cyc >= 60) begin
        o.timeout = 1; done = 1;
      end else begin
        cyc++;
        if (RegWrite) begin o.rw++; o.rw_at = cyc; o.rsrc = ResultSrc; end
        if (mem_we) o.we++;
        if (mem_req && AdrSrc) o.memc++;
        if (cyc == fw + 3) begin o.alu = ALUControl; o.alusrc = ALUSrc; end
        mem_rdata = $urandom;
        if (mem_req && !AdrSrc) begin
          if (f > 0) begin mem_ready = 1'b0; f--; end
          else begin mem_ready = 1'b1; mem_rdata = ins; fetched = 1; end
        end else if (mem_req && AdrSrc) begin
          if (m > 0) begin mem_ready = 1'b0; m--; end
          else mem_ready = 1'b1;
        end else begin
          mem_ready = 1'($urandom);
        end
        @(negedge CLK);
      end
    end
    o.cycles = cyc;
  endtask

  // Reset, then pulse trigger; returns at a negedge with the DUT in FETCH.
  task automatic start_run();
    rst = 1'b0; trigger = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    trigger = 1'b1;
    @(negedge CLK);
    trigger = 1'b0;
  endtask

  // Move PC to a chosen address with a JAL from the reset PC (0).
  task automatic goto_pc(input logic [31:0] target, input string tag);
    obs_t o;
    Zero = 1'b0; ImmExt = target;
    run_instr(32'h0000006F, 0, 0, o);
    check({tag, "_setup_pc"}, PC, target);
  endtask

  initial begin
    vec_t        vecs [15];
    vec_t        v;
    obs_t        o;
    exp_t        e;
    logic [31:0] pc_m, ins, pc_hold;
    int          fw, mw;

    rst = 1'b0; trigger = 1'b0; mem_ready = 1'b0; mem_rdata = '0; Zero = 1'b0; ImmExt = '0;

    //             ins           z     imm           fw mw start_pc     cyc pc            rw rsrc   alu     src   ca ck
    vecs[0]  = '{32'h00500093, 1'b0, 32'h00000005, 0, 0, 32'h00000000, 4, 32'h00000004, 1, 2'b00, 3'b000, 1'b1, 1, 1};
    vecs[1]  = '{32'h0000A103, 1'b0, 32'h00000000, 0, 3, 32'h00000000, 8, 32'h00000004, 1, 2'b01, 3'b000, 1'b1, 1, 1};
    vecs[2]  = '{32'h00000063, 1'b1, 32'hFFFFFFF8, 0, 0, 32'h00000010, 3, 32'h00000008, 0, 2'b00, 3'b001, 1'b0, 1, 1};
    vecs[3]  = '{32'h00000063, 1'b0, 32'hFFFFFFF8, 2, 0, 32'h00000010, 5, 32'h00000014, 0, 2'b00, 3'b001, 1'b0, 1, 1};
    vecs[4]  = '{32'h00001063, 1'b0, 32'h00000020, 0, 0, 32'h00000010, 3, 32'h00000030, 0, 2'b00, 3'b001, 1'b0, 1, 1};
    vecs[5]  = '{32'h002081B3, 1'b0, 32'h00000000, 0, 0, 32'hFFFFFFFC, 4, 32'h00000000, 1, 2'b00, 3'b000, 1'b0, 1, 1};
    vecs[6]  = '{32'h40208133, 1'b0, 32'h00000000, 1, 0, 32'h00000020, 5, 32'h00000024, 1, 2'b00, 3'b001, 1'b0, 1, 1};
    vecs[7]  = '{32'h0020A023, 1'b0, 32'h00000000, 1, 2, 32'h00000100, 7, 32'h00000104, 0, 2'b00, 3'b000, 1'b1, 1, 1};
    vecs[8]  = '{32'h008000EF, 1'b0, 32'h00000008, 0, 0, 32'h00000040, 4, 32'h00000048, 1, 2'b10, 3'b000, 1'b0, 0, 0};
    vecs[9]  = '{32'h123450B7, 1'b0, 32'h00000000, 2, 0, 32'h00000000, 6, 32'h00000004, 1, 2'b00, 3'b000, 1'b0, 1, 0};
    vecs[10] = '{32'h0020F1B3, 1'b0, 32'h00000000, 0, 0, 32'h00000000, 4, 32'h00000004, 1, 2'b00, 3'b010, 1'b0, 1, 1};
    vecs[11] = '{32'h0020E1B3, 1'b0, 32'h00000000, 0, 0, 32'h00000000, 4, 32'h00000004, 1, 2'b00, 3'b011, 1'b0, 1, 1};
    vecs[12] = '{32'h0020A1B3, 1'b0, 32'h00000000, 0, 0, 32'h00000000, 4, 32'h00000004, 1, 2'b00, 3'b101, 1'b0, 1, 1};
    vecs[13] = '{32'h40008093, 1'b0, 32'h00000400, 0, 0, 32'h00000000, 4, 32'h00000004, 1, 2'b00, 3'b000, 1'b1, 1, 1};
    vecs[14] = '{32'h00001063, 1'b1, 32'h00000020, 0, 0, 32'h00000010, 3, 32'h00000014, 0, 2'b00, 3'b001, 1'b0, 1, 1};

    // ---- Reset state, IDLE ignores inputs, first ADDI ----
    mem_ready = 1'b1; mem_rdata = 32'h00500093;
    repeat (2) @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    check("rst_pc", PC, 32'h0);
    check("rst_instr", Instr, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_halt", halt, 1'b0);
    check("rst_strobes", {mem_req, mem_we, AdrSrc, RegWrite, ALUSrc}, 5'b0);
    check("rst_resultsrc", ResultSrc, 2'b00);
    check("rst_aluctrl", ALUControl, 3'b000);
    Zero = 1'b1; ImmExt = 32'h44;
    repeat (3) @(negedge CLK);
    check("idle_ignores_busy", busy, 1'b0);
    check("idle_ignores_req", mem_req, 1'b0);
    trigger = 1'b1;
    @(negedge CLK);
    trigger = 1'b0;
    check("trig_busy", busy, 1'b1);
    check("trig_fetch", {mem_req, AdrSrc}, 2'b10);
    Zero = 1'b0; ImmExt = 32'h5;
    run_instr(32'h00500093, 0, 0, o);
    check("addi_timeout", o.timeout, 1'b0);
    check("addi_cycles", o.cycles, 4);
    check("addi_rw_count", o.rw, 1);
    check("addi_rw_cycle", o.rw_at, 4);
    check("addi_alusrc", o.alusrc, 1'b1);
    check("addi_pc", PC, 32'h4);

    // ---- Asynchronous reset in the middle of a stalled SW ----
    mem_rdata = 32'h0020A023; mem_ready = 1'b1;
    @(negedge CLK);
    mem_ready = 1'b0;
    repeat (2) @(negedge CLK);
    check("midmem_we_before", {mem_req, AdrSrc, mem_we}, 3'b111);
    #1 rst = 1'b0;
    #1;
    check("midmem_we_drop", mem_we, 1'b0);
    check("midmem_req_drop", mem_req, 1'b0);
    check("midmem_pc", PC, 32'h0);
    check("midmem_idle", busy, 1'b0);
    @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    trigger = 1'b1;
    @(negedge CLK);
    trigger = 1'b0;
    check("midfetch_req_before", mem_req, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("midfetch_req_drop", mem_req, 1'b0);
    check("midfetch_idle", busy, 1'b0);
    @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);

    // ---- Directed vector table ----
    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
      start_run();
      goto_pc(v.start_pc, $sformatf("vec%0d", i));
      Zero = v.zero; ImmExt = v.imm;
      run_instr(v.ins, v.fw, v.mw, o);
      check($sformatf("vec%0d_timeout", i), o.timeout, 1'b0);
      check($sformatf("vec%0d_cycles", i), o.cycles, v.exp_cycles);
      check($sformatf("vec%0d_pc", i), PC, v.exp_pc);
      check($sformatf("vec%0d_instr", i), Instr, v.ins);
      check($sformatf("vec%0d_rw", i), o.rw, v.exp_rw);
      if (v.exp_rw != 0) check($sformatf("vec%0d_rsrc", i), o.rsrc, v.exp_rsrc);
      if (v.chk_alu) check($sformatf("vec%0d_alu", i), o.alu, v.exp_alu);
      if (v.chk_src) check($sformatf("vec%0d_alusrc", i), o.alusrc, v.exp_alusrc);
    end

    // ---- Illegal opcode ----
    start_run();
    goto_pc(32'h80, "ill");
`ifdef MC_CTRL_TRAP_ILLEGAL_EN
    mem_rdata = 32'hFFFFFFFF; mem_ready = 1'b1;
    @(negedge CLK);
    mem_ready = 1'b0;
    repeat (4) @(negedge CLK);
    pc_hold = PC;
    check("ill_halt", halt, 1'b1);
    check("ill_busy", busy, 1'b1);
    check("ill_pc", pc_hold, 32'h80);
    check("ill_instr", Instr, 32'hFFFFFFFF);
    check("ill_strobes", {mem_req, mem_we, RegWrite}, 3'b000);
    trigger = 1'b1; mem_ready = 1'b1;
    repeat (3) @(negedge CLK);
    trigger = 1'b0;
    check("ill_trig_halt", halt, 1'b1);
    check("ill_trig_pc", PC, 32'h80);
    check("ill_trig_req", mem_req, 1'b0);
`else
    run_instr(32'hFFFFFFFF, 0, 0, o);
    pc_hold = PC;
    check("ill_timeout", o.timeout, 1'b0);
    check("ill_cycles", o.cycles, 2);
    check("ill_pc", pc_hold, 32'h84);
    check("ill_rw", o.rw, 0);
    check("ill_mem", o.memc, 0);
    check("ill_halt", halt, 1'b0);
`endif

    // ---- Random instruction stream against the model ----
    start_run();
    pc_m = 32'h0;
    for (int i = 0; i < 200; i++) begin
      ins = gen_instr();
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      Zero = 1'($urandom);
      ImmExt = ($urandom_range(0, 1) == 1) ? $urandom : (32'($urandom_range(0, 15)) * 32'd4 - 32'd32);
      e = predict(ins, pc_m, Zero, ImmExt, fw, mw);
      run_instr(ins, fw, mw, o);
      check($sformatf("rnd%0d_timeout", i), o.timeout, 1'b0);
      check($sformatf("rnd%0d_cycles", i), o.cycles, e.cycles);
      check($sformatf("rnd%0d_pc", i), PC, e.pc);
      check($sformatf("rnd%0d_instr", i), Instr, ins);
      check($sformatf("rnd%0d_rw", i), o.rw, e.rw);
      check($sformatf("rnd%0d_we", i), o.we, e.we);
      check($sformatf("rnd%0d_memc", i), o.memc, e.memc);
      if (e.rw != 0) check($sformatf("rnd%0d_rsrc", i), o.rsrc, e.rsrc);
      if (e.alu_known) check($sformatf("rnd%0d_alu", i), o.alu, e.alu);
      if (e.src_known) check($sformatf("rnd%0d_alusrc", i), o.alusrc, e.alusrc);
      check($sformatf("rnd%0d_halt", i), halt, 1'b0);
      pc_m = e.pc;
      if (o.timeout) break;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
